// File: rtl/pcs_rx_descrambler.sv
// Side-stream descrambler for the PCS receive path: locks onto idle traffic, then emits descrambled bytes.
// Define DESCRAMBLER_STATS_EN to add the io_lockLoss counter and the io_state debug outputs.
module pcs_rx_descrambler #(
  parameter int LOCK_COUNT = 16,
  parameter int MAX_NOIDLE = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_inData,
  input  logic        io_inValid,
  input  logic        io_master,
  output logic [7:0]  io_outData,
  output logic        io_outValid,
  output logic        io_locked
`ifdef DESCRAMBLER_STATS_EN
  ,
  output logic [15:0] io_lockLoss,
  output logic [1:0]  io_state
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]  LOCK_CNT_L   = LOCK_COUNT[7:0];
  localparam logic [15:0] MAX_NOIDLE_L = MAX_NOIDLE[15:0];

  state_t      state_reg;
  logic [32:0] lfsr_reg;
  logic [2:0]  byte_cnt_reg;
  logic [7:0]  good_cnt_reg;
  logic [15:0] wdog_reg;
  logic        master_reg;
  logic        master_seen_reg;
  logic [7:0]  out_data_reg;
  logic        out_valid_reg;
  logic        locked_reg;

  logic [32:0] gen_next;
  logic [32:0] hunt_next;
  logic [7:0]  keystream;
  logic [7:0]  desc_byte;
  logic [7:0]  good_next;
  logic [15:0] wdog_next;
  logic        master_chg;

  // Two views of the next LFSR value: free-running generation, and loading received bits in HUNT.
  always_comb begin
    gen_next  = lfsr_reg;
    hunt_next = lfsr_reg;
    keystream = 8'h00;
    for (int i = 0; i < 8; i++) begin
      keystream[i] = gen_next[32] ^ (master_reg ? gen_next[12] : gen_next[19]);
      gen_next     = {gen_next[31:0], keystream[i]};
      hunt_next    = {hunt_next[31:0], io_inData[i]};
    end
  end

  assign desc_byte  = io_inData ^ keystream;
  assign good_next  = good_cnt_reg + 8'd1;
  assign wdog_next  = wdog_reg + 16'd1;
  // The first edge after reset only captures io_master, so a static strap never looks like a toggle.
  assign master_chg = master_seen_reg && (io_master != master_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= HUNT;
      lfsr_reg        <= '0;
      byte_cnt_reg    <= '0;
      good_cnt_reg    <= '0;
      wdog_reg        <= '0;
      master_reg      <= 1'b0;
      master_seen_reg <= 1'b0;
      out_data_reg    <= 8'h00;
      out_valid_reg   <= 1'b0;
      locked_reg      <= 1'b0;
    end else begin
      master_reg      <= io_master;
      master_seen_reg <= 1'b1;
      if (master_chg) begin
        state_reg     <= HUNT;
        byte_cnt_reg  <= '0;
        good_cnt_reg  <= '0;
        wdog_reg      <= '0;
        out_valid_reg <= 1'b0;
        locked_reg    <= 1'b0;
      end else if (!io_inValid) begin
        out_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          HUNT: begin
            lfsr_reg      <= hunt_next;
            out_valid_reg <= 1'b0;
            if (byte_cnt_reg == 3'd4) begin
              byte_cnt_reg <= '0;
              if (hunt_next != '0) begin
                state_reg    <= CHECK;
                good_cnt_reg <= '0;
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
            end
          end
          CHECK: begin
            lfsr_reg      <= gen_next;
            out_valid_reg <= 1'b0;
            if (desc_byte == 8'h00) begin
              good_cnt_reg <= good_next;
              if (good_next == LOCK_CNT_L) begin
                state_reg <= LOCKED;
                wdog_reg  <= '0;
              end
            end else begin
              state_reg    <= HUNT;
              byte_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            lfsr_reg <= gen_next;
            if (desc_byte != 8'h00 && wdog_next == MAX_NOIDLE_L) begin
              state_reg     <= HUNT;
              byte_cnt_reg  <= '0;
              wdog_reg      <= '0;
              out_valid_reg <= 1'b0;
              locked_reg    <= 1'b0;
            end else begin
              wdog_reg      <= (desc_byte == 8'h00) ? 16'd0 : wdog_next;
              out_data_reg  <= desc_byte;
              out_valid_reg <= 1'b1;
              locked_reg    <= 1'b1;
            end
          end
          default: begin
            state_reg     <= HUNT;
            byte_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            locked_reg    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_outData  = out_data_reg;
  assign io_outValid = out_valid_reg;
  assign io_locked   = locked_reg;

`ifdef DESCRAMBLER_STATS_EN
  logic [15:0] lock_loss_reg;
  logic        lock_drop;

  assign lock_drop = (state_reg == LOCKED) &&
                     (master_chg || (io_inValid && desc_byte != 8'h00 && wdog_next == MAX_NOIDLE_L));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_loss_reg <= '0;
    end else if (lock_drop && lock_loss_reg != 16'hFFFF) begin
      lock_loss_reg <= lock_loss_reg + 16'd1;
    end
  end

  assign io_lockLoss = lock_loss_reg;
  assign io_state    = state_reg;
`endif

endmodule

// File: tb/tb_pcs_rx_descrambler.sv
// Directed bench for pcs_rx_descrambler: a reference scrambler feeds lock, payload, watchdog,
// polarity and reset scenarios; every expectation is the known plaintext or lock timing.
module tb_pcs_rx_descrambler;

  logic        clock;
  logic        reset;
  logic [7:0]  io_inData;
  logic        io_inValid;
  logic        io_master;
  logic [7:0]  io_outData;
  logic        io_outValid;
  logic        io_locked;
`ifdef DESCRAMBLER_STATS_EN
  logic [15:0] io_lockLoss;
  logic [1:0]  io_state;
`endif

  int          checks;
  int          errors;
  logic [32:0] tx_s;
  int          tx_tap;
  int          exp_loss;

  pcs_rx_descrambler #(.LOCK_COUNT(16), .MAX_NOIDLE(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_inData   (io_inData),
    .io_inValid  (io_inValid),
    .io_master   (io_master),
    .io_outData  (io_outData),
    .io_outValid (io_outValid),
    .io_locked   (io_locked)
`ifdef DESCRAMBLER_STATS_EN
    ,
    .io_lockLoss (io_lockLoss),
    .io_state    (io_state)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transmit-side scrambler: the receiver must undo exactly this.
  task automatic scramble(input logic [7:0] p, output logic [7:0] c);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b    = tx_s[32] ^ tx_s[tx_tap-1];
      c[i] = p[i] ^ b;
      tx_s = {tx_s[31:0], b};
    end
  endtask

  task automatic send_raw(input logic [7:0] c);
    io_inData  = c;
    io_inValid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] plain);
    logic [7:0] c;
    scramble(plain, c);
    send_raw(c);
  endtask

  task automatic idle();
    io_inValid = 1'b0;
    io_inData  = 8'h5A;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_stats(input string tag, input logic [1:0] st);
`ifdef DESCRAMBLER_STATS_EN
    chk({tag, "_state"}, 16'(io_state), 16'(st));
    chk({tag, "_lockloss"}, io_lockLoss, 16'(exp_loss));
`else
    if (st > 2'd2) $display("unexpected state code for %s", tag);
`endif
  endtask

  // 5 HUNT bytes + 16 CHECK bytes, then the first LOCKED byte is output.
  task automatic acquire(input string tag);
    for (int k = 0; k < 22; k++) begin
      send(8'h00);
      chk({tag, "_locked"}, 16'(io_locked), 16'(k == 21));
      chk({tag, "_valid"}, 16'(io_outValid), 16'(k == 21));
      if (k == 4) chk_stats({tag, "_check"}, 2'd1);
    end
    chk({tag, "_data"}, 16'(io_outData), 16'h0000);
    chk_stats({tag, "_lockedst"}, 2'd2);
  endtask

  initial begin
    logic [7:0] pay [4];
    logic [7:0] p;
    logic [7:0] last;
    checks     = 0;
    errors     = 0;
    exp_loss   = 0;
    reset      = 1'b0;
    io_master  = 1'b1;
    io_inValid = 1'b0;
    io_inData  = 8'h00;
    pay[0] = 8'h00; pay[1] = 8'hA5; pay[2] = 8'h3C; pay[3] = 8'hFF;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_data", 16'(io_outData), 16'h0000);
    chk("rst_valid", 16'(io_outValid), 16'h0000);
    chk("rst_locked", 16'(io_locked), 16'h0000);
    chk_stats("rst", 2'd0);
    @(negedge clock);
    reset = 1'b1;
    idle();

    // Acquire with TAP=13
    tx_s   = 33'h1_2345_6789;
    tx_tap = 13;
    acquire("acq1");

    // Payload back to back, then with gaps
    for (int i = 0; i < 4; i++) begin
      send(pay[i]);
      chk("pay_valid", 16'(io_outValid), 16'h0001);
      chk("pay_data", 16'(io_outData), 16'(pay[i]));
    end
    for (int i = 0; i < 4; i++) begin
      send(pay[i]);
      chk("gap_valid", 16'(io_outValid), 16'h0001);
      chk("gap_data", 16'(io_outData), 16'(pay[i]));
      idle();
      chk("gap_idle_valid", 16'(io_outValid), 16'h0000);
      chk("gap_idle_data", 16'(io_outData), 16'(pay[i]));
      chk("gap_idle_locked", 16'(io_locked), 16'h0001);
    end

    // Polarity change while locked, relock with TAP=20
    io_master = 1'b0;
    exp_loss++;
    idle();
    chk("pol_locked", 16'(io_locked), 16'h0000);
    chk_stats("pol", 2'd0);
    tx_tap = 20;
    acquire("acq20");

    // Back to TAP=13, then a failed CHECK
    io_master = 1'b1;
    exp_loss++;
    idle();
    chk("pol13_locked", 16'(io_locked), 16'h0000);
    tx_tap = 13;
    for (int k = 0; k < 8; k++) send(8'h00);
    chk_stats("chkfail_pre", 2'd1);
    send(8'h01);
    chk("chkfail_locked", 16'(io_locked), 16'h0000);
    chk("chkfail_valid", 16'(io_outValid), 16'h0000);
    chk_stats("chkfail", 2'd0);
    acquire("relock");

    // Watchdog: 8 non-idle bytes, the 8th drops lock
    last = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      p = 8'(i * 19);
      send(p);
      if (i < 8) begin
        chk("wd_valid", 16'(io_outValid), 16'h0001);
        chk("wd_data", 16'(io_outData), 16'(p));
        chk("wd_locked", 16'(io_locked), 16'h0001);
        last = p;
      end else begin
        exp_loss++;
        chk("wd_drop_valid", 16'(io_outValid), 16'h0000);
        chk("wd_drop_locked", 16'(io_locked), 16'h0000);
        chk("wd_drop_data", 16'(io_outData), 16'(last));
        chk_stats("wd_drop", 2'd0);
      end
    end

    // All-zero line never leaves HUNT
    for (int k = 0; k < 30; k++) begin
      send_raw(8'h00);
      chk("zero_locked", 16'(io_locked), 16'h0000);
      chk("zero_valid", 16'(io_outValid), 16'h0000);
    end
    chk_stats("zero", 2'd0);
    acquire("acq_after_zero");

    // Asynchronous reset between edges while locked
    send(8'h00);
    chk("pre_rst_valid", 16'(io_outValid), 16'h0001);
    #3;
    reset = 1'b0;
    #1;
    chk("async_valid", 16'(io_outValid), 16'h0000);
    chk("async_locked", 16'(io_locked), 16'h0000);
    chk("async_data", 16'(io_outData), 16'h0000);
    exp_loss = 0;
    chk_stats("async", 2'd0);
    #2;
    @(negedge clock);
    reset = 1'b1;
    tx_s   = 33'h1_2345_6789;
    tx_tap = 13;
    idle();
    acquire("acq_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
